// File: rtl/spm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spm_seq_ctrl
// Description : Sequencer for a serial-parallel multiplier (spm) built from a
//               chain of carry-save adder stages. It accepts an operand pair,
//               holds the multiplicand on the spm parallel input and streams
//               the multiplier into the spm serial input, LSB first. It then
//               collects the serial product bits and returns the 2*WIDTH-bit
//               product over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WIDTH   - operand width, must match the spm instance
//               SPM_LAT - cycles from driving spm_y bit k to spm_p bit k
// Ports       : clk        clock
//               rst        asynchronous reset, active-low
//               in_valid   operand pair valid       in_ready  accepting operands
//               in_a       multiplicand (parallel)  in_b      multiplier (serial)
//               out_valid  product valid            out_ready consumer accepts
//               out_p      2*WIDTH-bit product
//               spm_x      parallel operand to spm  spm_y     serial bit to spm
//               spm_clr    synchronous clear of spm csa state, active-high
//               spm_p      serial product bit from spm
//               busy       high in every state except IDLE
// Macro       : SPM_SEQ_CTRL_SIGNED_EN - two's complement operands; the serial
//               multiplier is sign-extended instead of zero-extended.
// ============================================================================
module spm_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int SPM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_y,
  output logic               spm_clr,
  input  logic               spm_p,
  output logic               busy
);

  localparam int C_RUN_LEN = 2*WIDTH + SPM_LAT;
  localparam int C_CW      = $clog2(C_RUN_LEN + 1);
  localparam logic [C_CW-1:0] C_LAST = C_CW'(C_RUN_LEN - 1);
  localparam logic [C_CW-1:0] C_LAT  = C_CW'(SPM_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [C_CW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_x;
  logic [2*WIDTH-1:0] r_p;
  logic               r_y;
  logic               r_clr;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  // Fill bit entering the top of the serial shift register. Once all WIDTH
  // multiplier bits have been shifted out, the spm keeps seeing this value.
  logic               w_fill;
  logic [WIDTH-1:0]   w_b_next;

`ifdef SPM_SEQ_CTRL_SIGNED_EN
  assign w_fill = r_b[WIDTH-1];
`else
  assign w_fill = 1'b0;
`endif

  assign w_b_next = {w_fill, r_b[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_b         <= '0;
      r_x         <= '0;
      r_p         <= '0;
      r_y         <= 1'b0;
      r_clr       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (in_valid && r_in_ready) begin
            r_x        <= in_a;
            r_b        <= in_b;
            r_p        <= '0;
            r_y        <= 1'b0;
            r_clr      <= 1'b1;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          // spm_y is registered, so b[0] is presented for RUN counter 0 and
          // r_b[0] then always holds the bit for the following RUN cycle.
          r_clr   <= 1'b0;
          r_y     <= r_b[0];
          r_b     <= w_b_next;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end

        S_RUN: begin
          r_cnt <= r_cnt + C_CW'(1);
          // The first SPM_LAT samples predate product bit 0. Shifting in
          // from the MSB leaves bit 0 at the LSB after 2*WIDTH captures.
          if (r_cnt >= C_LAT) begin
            r_p <= {spm_p, r_p[2*WIDTH-1:1]};
          end
          if (r_cnt == C_LAST) begin
            r_y         <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_y <= r_b[0];
            r_b <= w_b_next;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_p     = r_p;
  assign spm_x     = r_x;
  assign spm_y     = r_y;
  assign spm_clr   = r_clr;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_seq_ctrl
// Description : Self-checking bench for spm_seq_ctrl (WIDTH=8, SPM_LAT=1).
//               Contains a behavioural stand-in for the spm datapath and
//               compares products against plain arithmetic.
// Revision    : 1.0 - initial release
// Macro       : SPM_SEQ_CTRL_SIGNED_EN - expected values become signed.
// ============================================================================
module tb_spm_seq_ctrl;

  localparam int W   = 8;
  localparam int LAT = 1;
  localparam int RUN_LEN = 2*W + LAT;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic [W-1:0]   spm_x;
  logic           spm_y;
  logic           spm_clr;
  logic           spm_p;
  logic           busy;

  spm_seq_ctrl #(.WIDTH(W), .SPM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .spm_x(spm_x), .spm_y(spm_y), .spm_clr(spm_clr), .spm_p(spm_p),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural spm: accumulates x*y_k*2^k and returns bit k of the running
  // sum one cycle after y_k is presented (bits above k cannot change it).
  // ---------------------------------------------------------------------
  logic [2*W-1:0] m_acc;
  logic [4:0]     m_k;
  logic [2*W-1:0] m_xext;
  logic [2*W-1:0] m_nxt;
`ifdef SPM_SEQ_CTRL_SIGNED_EN
  assign m_xext = {{W{spm_x[W-1]}}, spm_x};
`else
  assign m_xext = {{W{1'b0}}, spm_x};
`endif
  assign m_nxt = m_acc + (spm_y ? (m_xext << m_k) : '0);

  always @(posedge clk) begin
    if (spm_clr) begin
      m_acc <= '0;
      m_k   <= '0;
      spm_p <= 1'b0;
    end else if (m_k < 5'(2*W)) begin
      m_acc <= m_nxt;
      spm_p <= m_nxt[m_k[3:0]];
      m_k   <= m_k + 5'd1;
    end else begin
      spm_p <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Reference arithmetic
  // ---------------------------------------------------------------------
  function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
`ifdef SPM_SEQ_CTRL_SIGNED_EN
    p = int'($signed(a)) * int'($signed(b));
`else
    p = int'(a) * int'(b);
`endif
    return p[2*W-1:0];
  endfunction

  function automatic logic exp_y(input logic [W-1:0] b, input int c);
    if (c < W) return b[c];
`ifdef SPM_SEQ_CTRL_SIGNED_EN
    return b[W-1];
`else
    return 1'b0;
`endif
  endfunction

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One operation with out_ready held high; returns product and latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] p, output int lat);
    int n;
    int c0;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    chk("op_in_ready", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b;
    c0 = cyc;
    step();
    in_valid = 1'b0;
    chk("op_clear", spm_clr, 1);
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    chk("op_done_seen", out_valid, 1);
    p   = out_p;
    lat = cyc - c0;
    step();
    chk("op_valid_one_cycle", out_valid, 0);
    chk("op_in_ready_back", in_ready, 1);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [2*W-1:0] p;
    int             lat;
    int             c0;
    int             bad;
    logic [W-1:0]   bb;
    logic [2*W-1:0] pe;
    int             acc_t[3];
    int             hand_t[3];
    logic [2*W-1:0] hand_p[3];
    int             na;
    int             nh;
    logic [2*W-1:0] q[$];
    int             nrx;

`ifdef SPM_SEQ_CTRL_SIGNED_EN
    tbl[0] = '{8'hFF, 8'hFF, 16'h0001};
    tbl[1] = '{8'h00, 8'hFF, 16'h0000};
    tbl[2] = '{8'hFF, 8'h00, 16'h0000};
    tbl[3] = '{8'd7,  8'd9,  16'h003F};
    tbl[4] = '{8'hC8, 8'd3,  16'hFF58};
    tbl[5] = '{8'd12, 8'd12, 16'h0090};
    tbl[6] = '{8'h01, 8'h80, 16'hFF80};
    tbl[7] = '{8'h80, 8'h80, 16'h4000};
    tbl[8] = '{8'hFD, 8'd5,  16'hFFF1};
    tbl[9] = '{8'd5,  8'hFD, 16'hFFF1};
`else
    tbl[0] = '{8'hFF, 8'hFF, 16'hFE01};
    tbl[1] = '{8'h00, 8'hFF, 16'h0000};
    tbl[2] = '{8'hFF, 8'h00, 16'h0000};
    tbl[3] = '{8'd7,  8'd9,  16'h003F};
    tbl[4] = '{8'd200, 8'd3, 16'h0258};
    tbl[5] = '{8'd12, 8'd12, 16'h0090};
    tbl[6] = '{8'h01, 8'h80, 16'h0080};
    tbl[7] = '{8'h80, 8'h80, 16'h4000};
    tbl[8] = '{8'hFD, 8'd5,  16'h04F1};
    tbl[9] = '{8'd5,  8'hFD, 16'h04F1};
`endif

    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    // ---------------- reset state ----------------
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_spm_x", spm_x, 0);
    chk("rst_spm_y", spm_y, 0);
    chk("rst_spm_clr", spm_clr, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    step();

    // ---------------- simple product with timing + backpressure ----------
    bb = 8'd5;
    pe = exp_prod(8'd3, bb);
    in_a = 8'd3; in_b = bb; in_valid = 1'b1; out_ready = 1'b0;
    c0 = cyc;
    step();
    in_valid = 1'b0;
    chk("simple_clr_c1", spm_clr, 1);
    chk("simple_in_ready_c1", in_ready, 0);
    chk("simple_busy_c1", busy, 1);
    chk("simple_spm_x", spm_x, 3);
    chk("simple_spm_y_clear", spm_y, 0);
    step();
    chk("simple_clr_c2", spm_clr, 0);
    bad = 0;
    for (int c = 0; c < RUN_LEN; c++) begin
      if (spm_y !== exp_y(bb, c)) bad++;
      if (spm_x !== 8'd3) bad++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      in_a = 8'($urandom);
      step();
    end
    chk("simple_run_stream", bad, 0);
    chk("simple_latency_cycle", cyc - c0, 2 + RUN_LEN);
    chk("simple_out_valid", out_valid, 1);
    chk("simple_out_p", out_p, pe);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 8'($urandom); in_b = 8'($urandom);
      step();
      if (out_valid !== 1'b1 || out_p !== pe || in_ready !== 1'b0 || spm_x !== 8'd3) bad++;
    end
    chk("bp_stable", bad, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);
    chk("bp_no_accept", busy, 0);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, p, lat);
      chk($sformatf("tbl%0d_prod", i), p, tbl[i].p);
      chk($sformatf("tbl%0d_lat", i), lat, 2 + RUN_LEN);
    end

    // ---------------- back-to-back ----------------
    na = 0; nh = 0;
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd9; out_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (in_valid && in_ready && na < 3) begin acc_t[na] = cyc; na++; end
      if (out_valid && out_ready && nh < 3) begin hand_t[nh] = cyc; hand_p[nh] = out_p; nh++; end
      if (nh == 2) break;
      step();
      if (na == 1) begin in_a = 8'd200; in_b = 8'd3; end
    end
    in_valid = 1'b0;
    chk("b2b_two_products", nh, 2);
    if (nh == 2 && na >= 2) begin
      chk("b2b_prod0", hand_p[0], exp_prod(8'd7, 8'd9));
      chk("b2b_prod1", hand_p[1], exp_prod(8'd200, 8'd3));
      chk("b2b_reaccept_gap", acc_t[1] - hand_t[0], 1);
      chk("b2b_spacing", hand_t[1] - hand_t[0], 3 + RUN_LEN);
    end
    step();

    // ---------------- reset mid-RUN ----------------
    in_a = 8'd12; in_b = 8'd12; in_valid = 1'b1; out_ready = 1'b1;
    step();            // now CLEAR
    in_valid = 1'b0;
    step();            // RUN counter 0
    for (int i = 0; i < 5; i++) step();  // RUN counter 5
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_p", out_p, 0);
    chk("mid_rst_spm_x", spm_x, 0);
    chk("mid_rst_spm_clr", spm_clr, 0);
    chk("mid_rst_busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    rst = 1'b1;
    for (int i = 0; i < RUN_LEN + 5; i++) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("mid_rst_no_pulse", bad, 0);
    run_op(8'd12, 8'd12, p, lat);
    chk("post_rst_prod", p, exp_prod(8'd12, 8'd12));

    // ---------------- randomized with scoreboard ----------------
    nrx = 0;
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a = 8'($urandom); in_b = 8'($urandom);
      if (in_valid && in_ready) q.push_back(exp_prod(in_a, in_b));
      if (out_valid && out_ready) begin
        chk("rnd_sb_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) chk("rnd_prod", out_p, q.pop_front());
        nrx++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 60 && busy; i++) begin
      if (out_valid && out_ready) begin
        chk("rnd_sb_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) chk("rnd_prod", out_p, q.pop_front());
        nrx++;
      end
      step();
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_enough_ops", (nrx >= 50), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
